img_ram_mp: RTL and testbench



---
 rtl/img_ram_pkg.sv | 26 ++
 rtl/img_ram_rd_pipe.sv | 43 ++++
 rtl/img_ram_mp.sv | 150 +++++++++++++++
 tb/tb_img_ram_mp.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_ram_pkg.sv
// Shared types and constants for the multi-read-port image buffer.
// Holds the FSM state enum, read-during-write mode codes and parameter checks.
package img_ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    localparam int RD_FIRST = 0;
    localparam int WR_FIRST = 1;

    // Legal configuration space of img_ram_mp.
    function automatic bit params_ok(
        input int depth,
        input int num_rd,
        input int read_lat,
        input int rd_mode
    );
        return (depth >= 2)
            && (num_rd >= 1) && (num_rd <= 8)
            && (read_lat >= 1) && (read_lat <= 4)
            && ((rd_mode == RD_FIRST) || (rd_mode == WR_FIRST));
    endfunction

endpackage

// File: rtl/img_ram_rd_pipe.sv
// Read-data/valid delay pipe of LAT stages for one read port of img_ram_mp.
// Ports: i_clk, i_flush_n (sync active-low flush), i_valid/i_data in, o_valid/o_data out.
module img_ram_rd_pipe #(
    parameter int WIDTH = 8,
    parameter int LAT   = 1
) (
    input  logic             i_clk,
    input  logic             i_flush_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic [LAT-1:0]   r_vld;
    logic [WIDTH-1:0] r_dat [LAT];

    // Data only advances behind a valid, so the last stage holds the
    // most recent returned word while no read is in flight.
    always_ff @(posedge i_clk) begin
        if (!i_flush_n) begin
            r_vld <= '0;
            for (int k = 0; k < LAT; k++) begin
                r_dat[k] <= '0;
            end
        end else begin
            r_vld[0] <= i_valid;
            if (i_valid) begin
                r_dat[0] <= i_data;
            end
            for (int k = 1; k < LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                if (r_vld[k-1]) begin
                    r_dat[k] <= r_dat[k-1];
                end
            end
        end
    end

    assign o_valid = r_vld[LAT-1];
    assign o_data  = r_dat[LAT-1];

endmodule

// File: rtl/img_ram_mp.sv
// Image frame buffer: one write port, NUM_RD pipelined read ports, clear sweep.
// Ports: clk, rst (sync active-low), clear_req, ready, wen_0/waddr_0/wdata_0,
//        ren/raddr/rdata/rvalid (packed per port). With IMG_RAM_DEBUG_EN defined:
//        debug_write_en/addr/data (write, wins over wen_0) and debug_addr/debug_data.
module img_ram_mp
    import img_ram_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 4096,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int NUM_RD     = 2,
    parameter int READ_LAT   = 1,
    parameter int RD_MODE    = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear_req,
    output logic                         ready,
    input  logic                         wen_0,
    input  logic [ADDR_WIDTH-1:0]        waddr_0,
    input  logic [WIDTH-1:0]             wdata_0,
    input  logic [NUM_RD-1:0]            ren,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*WIDTH-1:0]      rdata,
    output logic [NUM_RD-1:0]            rvalid
`ifdef IMG_RAM_DEBUG_EN
    ,
    input  logic                         debug_write_en,
    input  logic [ADDR_WIDTH-1:0]        debug_write_addr,
    input  logic [WIDTH-1:0]             debug_write_data,
    input  logic [ADDR_WIDTH-1:0]        debug_addr,
    output logic [WIDTH-1:0]             debug_data
`endif
);

    if (!params_ok(DEPTH, NUM_RD, READ_LAT, RD_MODE)) begin : g_bad_params
        $error("img_ram_mp: illegal parameter combination");
    end

    function automatic logic in_rng(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a) < DEPTH;
    endfunction

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic                  w_run;
    logic                  w_clearing;
    logic                  w_clr_last;
    logic                  w_wr_ok;
    logic [WIDTH-1:0]      r_mem [DEPTH];

    assign w_clr_last = (r_clr_cnt == ADDR_WIDTH'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_CLEAR: if (w_clr_last) w_state_nxt = ST_RUN;
            ST_RUN:   if (clear_req)  w_state_nxt = ST_CLEAR;
            default:  w_state_nxt = ST_CLEAR;
        endcase
    end

    always_comb begin
        w_run      = (r_state == ST_RUN);
        w_clearing = (r_state == ST_CLEAR);
    end

    assign ready = w_run;

    // Counter idles at 0 in RUN so a clear request always sweeps from word 0.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_clr_cnt <= '0;
        end else if (w_clearing) begin
            r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
        end else begin
            r_clr_cnt <= '0;
        end
    end

    assign w_wr_ok = rst && w_run && wen_0 && in_rng(waddr_0);

`ifdef IMG_RAM_DEBUG_EN
    logic w_dbg_ok;
    assign w_dbg_ok   = rst && w_run && debug_write_en && in_rng(debug_write_addr);
    assign debug_data = in_rng(debug_addr) ? r_mem[debug_addr] : '0;
`endif

    // Debug write is ordered last so it wins an address collision.
    always_ff @(posedge clk) begin
        if (rst && w_clearing) begin
            r_mem[r_clr_cnt] <= '0;
        end
        if (w_wr_ok) begin
            r_mem[waddr_0] <= wdata_0;
        end
`ifdef IMG_RAM_DEBUG_EN
        if (w_dbg_ok) begin
            r_mem[debug_write_addr] <= debug_write_data;
        end
`endif
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_ra;
        logic [WIDTH-1:0]      w_rd;

        assign w_ra = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];

        // Write-first forwards the word being written this cycle.
        always_comb begin
            w_rd = '0;
            if (in_rng(w_ra)) begin
                w_rd = r_mem[w_ra];
                if (RD_MODE == WR_FIRST) begin
                    if (w_wr_ok && (waddr_0 == w_ra)) begin
                        w_rd = wdata_0;
                    end
`ifdef IMG_RAM_DEBUG_EN
                    if (w_dbg_ok && (debug_write_addr == w_ra)) begin
                        w_rd = debug_write_data;
                    end
`endif
                end
            end
        end

        img_ram_rd_pipe #(
            .WIDTH (WIDTH),
            .LAT   (READ_LAT)
        ) u_pipe (
            .i_clk     (clk),
            .i_flush_n (rst),
            .i_valid   (ren[i] && w_run),
            .i_data    (w_rd),
            .o_valid   (rvalid[i]),
            .o_data    (rdata[i*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_img_ram_mp.sv
// Self-checking bench for img_ram_mp: read-first and write-first instances
// driven in parallel against a cycle-level behavioural frame-store model.
module tb_img_ram_mp;

    localparam int DW  = 8;
    localparam int DEP = 12;
    localparam int AW  = 4;
    localparam int NR  = 2;
    localparam int LAT = 2;

    logic           clk;
    logic           rst;
    logic           clear_req;
    logic           wen_0;
    logic [AW-1:0]  waddr_0;
    logic [DW-1:0]  wdata_0;
    logic [NR-1:0]  ren;
    logic [NR*AW-1:0] raddr;
    logic           ready_rf, ready_wf;
    logic [NR*DW-1:0] rdata_rf, rdata_wf;
    logic [NR-1:0]  rvalid_rf, rvalid_wf;
`ifdef IMG_RAM_DEBUG_EN
    logic           debug_write_en;
    logic [AW-1:0]  debug_write_addr;
    logic [DW-1:0]  debug_write_data;
    logic [AW-1:0]  debug_addr;
    logic [DW-1:0]  debug_data_rf, debug_data_wf;
`endif

    img_ram_mp #(
        .WIDTH(DW), .DEPTH(DEP), .ADDR_WIDTH(AW),
        .NUM_RD(NR), .READ_LAT(LAT), .RD_MODE(0)
    ) u_rf (
        .clk(clk), .rst(rst), .clear_req(clear_req), .ready(ready_rf),
        .wen_0(wen_0), .waddr_0(waddr_0), .wdata_0(wdata_0),
        .ren(ren), .raddr(raddr), .rdata(rdata_rf), .rvalid(rvalid_rf)
`ifdef IMG_RAM_DEBUG_EN
        , .debug_write_en(debug_write_en), .debug_write_addr(debug_write_addr),
        .debug_write_data(debug_write_data), .debug_addr(debug_addr),
        .debug_data(debug_data_rf)
`endif
    );

    img_ram_mp #(
        .WIDTH(DW), .DEPTH(DEP), .ADDR_WIDTH(AW),
        .NUM_RD(NR), .READ_LAT(LAT), .RD_MODE(1)
    ) u_wf (
        .clk(clk), .rst(rst), .clear_req(clear_req), .ready(ready_wf),
        .wen_0(wen_0), .waddr_0(waddr_0), .wdata_0(wdata_0),
        .ren(ren), .raddr(raddr), .rdata(rdata_wf), .rvalid(rvalid_wf)
`ifdef IMG_RAM_DEBUG_EN
        , .debug_write_en(debug_write_en), .debug_write_addr(debug_write_addr),
        .debug_write_data(debug_write_data), .debug_addr(debug_addr),
        .debug_data(debug_data_wf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors;
    int checks;
    int ecnt;
    int clr_left;
    logic [DW-1:0] m_mem [DEP];
    bit            sch_v [2][NR][8];
    logic [DW-1:0] sch_d [2][NR][8];
    logic [DW-1:0] m_hold [2][NR];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic zero_mem();
        for (int a = 0; a < DEP; a++) m_mem[a] = '0;
    endtask

    // Value landing at address a this cycle, if any (debug write wins).
    task automatic eff_write(input int a, output bit hit, output logic [DW-1:0] v);
        hit = 0;
        v   = '0;
        if (wen_0 && int'(waddr_0) < DEP && int'(waddr_0) == a) begin
            hit = 1;
            v   = wdata_0;
        end
`ifdef IMG_RAM_DEBUG_EN
        if (debug_write_en && int'(debug_write_addr) < DEP && int'(debug_write_addr) == a) begin
            hit = 1;
            v   = debug_write_data;
        end
`endif
    endtask

    task automatic idle();
        wen_0     = 0;
        ren       = '0;
        clear_req = 0;
`ifdef IMG_RAM_DEBUG_EN
        debug_write_en = 0;
`endif
    endtask

    // Advance model and DUTs by one clock edge, then compare all outputs.
    task automatic step();
        bit            hit;
        logic [DW-1:0] v;
        logic [DW-1:0] rv;
        int            a;
        int            slot;
        ecnt++;
        if (!rst) begin
            for (int m = 0; m < 2; m++)
                for (int p = 0; p < NR; p++) begin
                    m_hold[m][p] = '0;
                    for (int s = 0; s < 8; s++) sch_v[m][p][s] = 0;
                end
            clr_left = DEP;
            zero_mem();
        end else if (clr_left > 0) begin
            clr_left--;
        end else begin
            for (int p = 0; p < NR; p++) begin
                if (ren[p]) begin
                    a = int'(raddr[p*AW +: AW]);
                    for (int m = 0; m < 2; m++) begin
                        rv = (a < DEP) ? m_mem[a] : '0;
                        if (m == 1 && a < DEP) begin
                            eff_write(a, hit, v);
                            if (hit) rv = v;
                        end
                        sch_v[m][p][(ecnt + LAT - 1) % 8] = 1;
                        sch_d[m][p][(ecnt + LAT - 1) % 8] = rv;
                    end
                end
            end
            for (int w = 0; w < DEP; w++) begin
                eff_write(w, hit, v);
                if (hit) m_mem[w] = v;
            end
            if (clear_req) begin
                clr_left = DEP;
                zero_mem();
            end
        end
        @(posedge clk);
        #1;
        slot = ecnt % 8;
        for (int m = 0; m < 2; m++) begin
            logic [NR*DW-1:0] rd;
            logic [NR-1:0]    vl;
            logic             rdy;
            rd  = (m == 0) ? rdata_rf  : rdata_wf;
            vl  = (m == 0) ? rvalid_rf : rvalid_wf;
            rdy = (m == 0) ? ready_rf  : ready_wf;
            chk($sformatf("ready m%0d e%0d", m, ecnt), 32'(rdy), 32'(clr_left == 0));
            for (int p = 0; p < NR; p++) begin
                bit ev;
                ev = sch_v[m][p][slot];
                if (ev) m_hold[m][p] = sch_d[m][p][slot];
                sch_v[m][p][slot] = 0;
                chk($sformatf("rvalid m%0d p%0d e%0d", m, p, ecnt), 32'(vl[p]), 32'(ev));
                chk($sformatf("rdata m%0d p%0d e%0d", m, p, ecnt),
                    32'(rd[p*DW +: DW]), 32'(m_hold[m][p]));
            end
        end
`ifdef IMG_RAM_DEBUG_EN
        if (clr_left == 0) begin
            a  = int'(debug_addr);
            rv = (a < DEP) ? m_mem[a] : '0;
            chk($sformatf("dbg rf e%0d", ecnt), 32'(debug_data_rf), 32'(rv));
            chk($sformatf("dbg wf e%0d", ecnt), 32'(debug_data_wf), 32'(rv));
        end
`endif
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        ecnt     = 0;
        clr_left = DEP;
        zero_mem();
        rst     = 0;
        raddr   = '0;
        waddr_0 = '0;
        wdata_0 = '0;
`ifdef IMG_RAM_DEBUG_EN
        debug_write_addr = '0;
        debug_write_data = '0;
        debug_addr       = '0;
`endif
        idle();
        repeat (2) step();

        // Sweep after reset release, then every address (incl. out of range).
        rst = 1;
        repeat (DEP + 2) step();
        for (int a = 0; a < 16; a++) begin
            ren   = 2'b11;
            raddr = {4'(15 - a), 4'(a)};
            step();
        end
        idle();
        repeat (2) step();

        // Write then read two cycles of latency.
        wen_0 = 1; waddr_0 = 4'd3; wdata_0 = 8'hA5;
        step();
        idle();
        ren = 2'b01; raddr = {4'd0, 4'd3};
        step();
        idle();
        step();
        chk("a5 valid", 32'(rvalid_rf[0]), 32'd1);
        chk("a5 data", 32'(rdata_rf[7:0]), 32'hA5);

        // Read-during-write on address 5.
        wen_0 = 1; waddr_0 = 4'd5; wdata_0 = 8'h22;
        step();
        wen_0 = 1; waddr_0 = 4'd5; wdata_0 = 8'h11;
        ren = 2'b01; raddr = {4'd0, 4'd5};
        step();
        idle();
        step();
        chk("rdw read-first", 32'(rdata_rf[7:0]), 32'h22);
        chk("rdw write-first", 32'(rdata_wf[7:0]), 32'h11);

        // Back-to-back reads on both ports while writing.
        for (int i = 0; i < 10; i++) begin
            ren     = 2'b11;
            raddr   = {4'd8, 4'd7};
            wen_0   = 1;
            waddr_0 = (i % 2 == 1) ? 4'd8 : 4'd7;
            wdata_0 = 8'(i + 1);
            step();
        end
        idle();
        repeat (2) step();

        // Fill with 0xFF, clear, reads ignored during sweep.
        for (int a = 0; a < DEP; a++) begin
            wen_0 = 1; waddr_0 = 4'(a); wdata_0 = 8'hFF;
            step();
        end
        idle();
        clear_req = 1;
        step();
        clear_req = 0;
        for (int i = 0; i < DEP; i++) begin
            ren     = 2'b11;
            raddr   = 8'($urandom);
            wen_0   = 1;
            waddr_0 = 4'($urandom);
            wdata_0 = 8'($urandom);
            step();
        end
        idle();
        step();
        for (int a = 0; a < DEP; a++) begin
            ren   = 2'b11;
            raddr = {4'(DEP - 1 - a), 4'(a)};
            step();
        end
        idle();
        repeat (2) step();

`ifdef IMG_RAM_DEBUG_EN
        debug_write_en = 1; debug_write_addr = 4'd9; debug_write_data = 8'h3C;
        wen_0 = 1; waddr_0 = 4'd9; wdata_0 = 8'h77;
        debug_addr = 4'd9;
        step();
        idle();
        chk("dbg win", 32'(debug_data_rf), 32'h3C);
        debug_addr = 4'd14;
        #1;
        chk("dbg oor", 32'(debug_data_rf), 32'h0);
`endif

        // Randomized traffic with occasional clears and resets.
        repeat (400) begin
            wen_0     = 1'($urandom);
            waddr_0   = 4'($urandom);
            wdata_0   = 8'($urandom);
            ren       = 2'($urandom);
            raddr     = 8'($urandom);
            clear_req = ($urandom_range(0, 79) == 0);
            rst       = ($urandom_range(0, 199) != 0);
`ifdef IMG_RAM_DEBUG_EN
            debug_write_en   = ($urandom_range(0, 3) == 0);
            debug_write_addr = 4'($urandom);
            debug_write_data = 8'($urandom);
            debug_addr       = 4'($urandom);
`endif
            step();
        end
        rst = 1;
        idle();
        repeat (DEP + 4) step();

        // Reset while reads are in flight.
        ren = 2'b11; raddr = {4'd2, 4'd1};
        step();
        rst = 0;
        idle();
        step();
        rst = 1;
        repeat (DEP + 3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
